// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants and types for the hazard/forwarding unit: control-vector bit
// positions, forwarding select encodings and the shadow-stage record.
package hazard_forward_unit_pkg;

    localparam int HAZ_WANT_RS_ID = 7;
    localparam int HAZ_NEED_RS_ID = 6;
    localparam int HAZ_WANT_RT_ID = 5;
    localparam int HAZ_NEED_RT_ID = 4;
    localparam int HAZ_WANT_RS_EX = 3;
    localparam int HAZ_NEED_RS_EX = 2;
    localparam int HAZ_WANT_RT_EX = 1;
    localparam int HAZ_NEED_RT_EX = 0;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef struct packed {
        logic [4:0] dest;
        logic       wr;
        logic       ld;
    } stage_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } ex_src_t;

    localparam stage_t  STAGE_BUBBLE = '0;
    localparam ex_src_t EX_SRC_NONE  = '0;

    // $0 is hard-wired zero, so it can never be a producer worth tracking.
    function automatic logic reg_match(input logic wr, input logic [4:0] dest,
                                       input logic [4:0] r);
        return wr && (dest == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage bundle between the decode/control side (master) and the hazard unit (slave).
interface hazard_forward_unit_if;

    logic [7:0] id_signal_forwarding;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_is_mul;
    logic       mem_stall;

    logic       if_stall;
    logic       id_stall;
    logic       ex_stall;
    logic [1:0] id_fwd_rs_sel;
    logic [1:0] id_fwd_rt_sel;
    logic [1:0] ex_fwd_rs_sel;
    logic [1:0] ex_fwd_rt_sel;

    modport master (
        output id_signal_forwarding, id_rs, id_rt, id_dest,
               id_reg_write, id_mem_read, id_is_mul, mem_stall,
        input  if_stall, id_stall, ex_stall,
               id_fwd_rs_sel, id_fwd_rt_sel, ex_fwd_rs_sel, ex_fwd_rt_sel
    );

    modport slave (
        input  id_signal_forwarding, id_rs, id_rt, id_dest,
               id_reg_write, id_mem_read, id_is_mul, mem_stall,
        output if_stall, id_stall, ex_stall,
               id_fwd_rs_sel, id_fwd_rt_sel, ex_fwd_rs_sel, ex_fwd_rt_sel
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forwarding source select for one source register: MEM ALU result beats WB data,
// and a load sitting in MEM is never a forwarding source.
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
(
    input  logic [4:0] r,
    input  logic       want,
    input  logic [4:0] mem_dest,
    input  logic       mem_wr,
    input  logic       mem_ld,
    input  logic [4:0] wb_dest,
    input  logic       wb_wr,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REGFILE;
        if (want && reg_match(mem_wr, mem_dest, r) && !mem_ld) begin
            sel = FWD_MEM;
        end else if (want && reg_match(wb_wr, wb_dest, r)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard detection and forwarding control: tracks EX/MEM/WB producers in a
// shadow pipeline, raises stall lines and sequences the multi-cycle MUL in EX.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input logic                  clock,
    input logic                  reset_n,
    hazard_forward_unit_if.slave bus
);

    localparam int               CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    stage_t           ex_q, ex_d;
    stage_t           mem_q, mem_d;
    ex_src_t          ex_src_q, ex_src_d;
    logic [4:0]       wb_dest_q, wb_dest_d;
    logic             wb_wr_q, wb_wr_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    logic [7:0] fsig;
    logic       mul_busy;
    logic       haz_rs;
    logic       haz_rt;
    logic       ex_stall;
    logic       id_stall;
    logic [1:0] id_rs_sel, id_rt_sel, ex_rs_sel, ex_rt_sel;

    assign fsig     = bus.id_signal_forwarding;
    assign mul_busy = (mul_cnt_q != '0);

    // ID hazards: result still in EX, load still in MEM, or load-use into EX.
    assign haz_rs = (fsig[HAZ_NEED_RS_ID] &&
                     (reg_match(ex_q.wr, ex_q.dest, bus.id_rs) ||
                      (reg_match(mem_q.wr, mem_q.dest, bus.id_rs) && mem_q.ld))) ||
                    (fsig[HAZ_NEED_RS_EX] && reg_match(ex_q.wr, ex_q.dest, bus.id_rs) && ex_q.ld);
    assign haz_rt = (fsig[HAZ_NEED_RT_ID] &&
                     (reg_match(ex_q.wr, ex_q.dest, bus.id_rt) ||
                      (reg_match(mem_q.wr, mem_q.dest, bus.id_rt) && mem_q.ld))) ||
                    (fsig[HAZ_NEED_RT_EX] && reg_match(ex_q.wr, ex_q.dest, bus.id_rt) && ex_q.ld);

    assign ex_stall = mul_busy | bus.mem_stall;
    assign id_stall = haz_rs | haz_rt | ex_stall;

    assign bus.ex_stall      = ex_stall;
    assign bus.id_stall      = id_stall;
    assign bus.if_stall      = id_stall;
    assign bus.id_fwd_rs_sel = id_rs_sel;
    assign bus.id_fwd_rt_sel = id_rt_sel;
    assign bus.ex_fwd_rs_sel = ex_rs_sel;
    assign bus.ex_fwd_rt_sel = ex_rt_sel;

    // Shadow pipeline advance; a busy MUL holds EX and drains bubbles into MEM.
    always_comb begin
        ex_d      = ex_q;
        ex_src_d  = ex_src_q;
        mem_d     = mem_q;
        wb_dest_d = wb_dest_q;
        wb_wr_d   = wb_wr_q;
        mul_cnt_d = mul_cnt_q;
        if (!bus.mem_stall) begin
            wb_dest_d = mem_q.dest;
            wb_wr_d   = mem_q.wr;
            if (mul_busy) begin
                mem_d     = STAGE_BUBBLE;
                mul_cnt_d = mul_cnt_q - CNT_W'(1);
            end else begin
                mem_d = ex_q;
                if (id_stall) begin
                    ex_d     = STAGE_BUBBLE;
                    ex_src_d = EX_SRC_NONE;
                end else begin
                    ex_d.dest       = bus.id_dest;
                    ex_d.wr         = bus.id_reg_write;
                    ex_d.ld         = bus.id_mem_read;
                    ex_src_d.rs     = bus.id_rs;
                    ex_src_d.rt     = bus.id_rt;
                    ex_src_d.use_rs = fsig[HAZ_WANT_RS_EX] | fsig[HAZ_NEED_RS_EX];
                    ex_src_d.use_rt = fsig[HAZ_WANT_RT_EX] | fsig[HAZ_NEED_RT_EX];
                    if (bus.id_is_mul) begin
                        mul_cnt_d = MUL_LOAD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q      <= STAGE_BUBBLE;
            ex_src_q  <= EX_SRC_NONE;
            mem_q     <= STAGE_BUBBLE;
            wb_dest_q <= '0;
            wb_wr_q   <= 1'b0;
            mul_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            ex_src_q  <= ex_src_d;
            mem_q     <= mem_d;
            wb_dest_q <= wb_dest_d;
            wb_wr_q   <= wb_wr_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    hazard_forward_unit_fwd_select u_id_rs (
        .r(bus.id_rs), .want(fsig[HAZ_WANT_RS_ID]),
        .mem_dest(mem_q.dest), .mem_wr(mem_q.wr), .mem_ld(mem_q.ld),
        .wb_dest(wb_dest_q), .wb_wr(wb_wr_q), .sel(id_rs_sel)
    );

    hazard_forward_unit_fwd_select u_id_rt (
        .r(bus.id_rt), .want(fsig[HAZ_WANT_RT_ID]),
        .mem_dest(mem_q.dest), .mem_wr(mem_q.wr), .mem_ld(mem_q.ld),
        .wb_dest(wb_dest_q), .wb_wr(wb_wr_q), .sel(id_rt_sel)
    );

    hazard_forward_unit_fwd_select u_ex_rs (
        .r(ex_src_q.rs), .want(ex_src_q.use_rs),
        .mem_dest(mem_q.dest), .mem_wr(mem_q.wr), .mem_ld(mem_q.ld),
        .wb_dest(wb_dest_q), .wb_wr(wb_wr_q), .sel(ex_rs_sel)
    );

    hazard_forward_unit_fwd_select u_ex_rt (
        .r(ex_src_q.rt), .want(ex_src_q.use_rt),
        .mem_dest(mem_q.dest), .mem_wr(mem_q.wr), .mem_ld(mem_q.ld),
        .wb_dest(wb_dest_q), .wb_wr(wb_wr_q), .sel(ex_rt_sel)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: instruction sequences drive the ID bundle,
// expected stall/select vectors go through a scoreboard queue.
module tb_hazard_forward_unit;

    localparam logic [7:0] SIG_NOP = 8'h00;
    localparam logic [7:0] SIG_ALU = 8'h0F;
    localparam logic [7:0] SIG_LW  = 8'h0C;
    localparam logic [7:0] SIG_BR  = 8'hF0;
    localparam logic [7:0] SIG_ALL = 8'hFF;

    typedef struct {
        string       tag;
        logic [10:0] vec;
    } exp_t;

    logic   clock;
    logic   reset_n;
    exp_t   sb[$];
    int     total;
    int     bad;

    hazard_forward_unit_if bus ();

    hazard_forward_unit #(.MUL_CYCLES(3)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic drive(input logic [7:0] s, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic wr, input logic ld,
                         input logic mul, input logic ms);
        bus.id_signal_forwarding = s;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_dest      = dest;
        bus.id_reg_write = wr;
        bus.id_mem_read  = ld;
        bus.id_is_mul    = mul;
        bus.mem_stall    = ms;
    endtask

    // Vector layout: {if_stall, id_stall, ex_stall, id_rs, id_rt, ex_rs, ex_rt}.
    task automatic expect_out(input string tag, input logic ids, input logic exs,
                              input logic [1:0] irs, input logic [1:0] irt,
                              input logic [1:0] ers, input logic [1:0] ert);
        exp_t e;
        e.tag = tag;
        e.vec = {ids, ids, exs, irs, irt, ers, ert};
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [10:0] obs;
        obs = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.id_fwd_rs_sel,
               bus.id_fwd_rt_sel, bus.ex_fwd_rs_sel, bus.ex_fwd_rt_sel};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got %b required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                bad++;
                $error("FAIL %s: got %b required %b", e.tag, obs, e.vec);
            end
        end
    endtask

    task automatic cycle_check();
        @(negedge clock);
        check_now();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        drive(SIG_BR, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        expect_out("reset_state", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_now();
        #10 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // ALU result consumed by a branch in ID
        drive(SIG_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t1_addu", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_BR, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t1_beq_stall", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        expect_out("t1_beq_fwd_mem", 0, 0, 2'b01, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_ALU, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t1_release", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();

        // load-use into an ALU op
        drive(SIG_LW, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("t2_lw", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_ALU, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t2_loaduse_stall", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        expect_out("t2_loaduse_release", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t2_ex_fwd_wb", 0, 0, 2'b00, 2'b00, 2'b10, 2'b00); cycle_check();

        // load feeding a branch: two stall cycles
        drive(SIG_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("t2b_lw", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_BR, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t2b_stall1", 1, 0, 2'b00, 2'b10, 2'b00, 2'b00); cycle_check();
        expect_out("t2b_stall2", 1, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        expect_out("t2b_fwd_wb", 0, 0, 2'b10, 2'b00, 2'b00, 2'b00); cycle_check();

        // register $0
        drive(SIG_ALU, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t3_write_r0", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_ALL, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t3_read_r0", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t3_ex_r0", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();

        // MUL occupies EX for three cycles
        drive(SIG_ALU, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("t4_mul_issue", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_ALU, 5'd10, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t4_mul_busy1", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        expect_out("t4_mul_busy2", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        expect_out("t4_mul_done", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t4_fwd_mem", 0, 0, 2'b00, 2'b00, 2'b01, 2'b00); cycle_check();

        // memory stall during a load-use
        drive(SIG_LW, 5'd11, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("t5_lw", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_ALU, 5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_out("t5_memstall", 1, 1, 2'b00, 2'b00, 2'b10, 2'b00); cycle_check();
        end
        drive(SIG_ALU, 5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("t5_resume_stall", 1, 0, 2'b00, 2'b00, 2'b10, 2'b00); cycle_check();
        expect_out("t5_resume_release", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t5_fwd_wb", 0, 0, 2'b00, 2'b00, 2'b10, 2'b10); cycle_check();

        // MUL counter frozen by mem_stall, then async reset mid-MUL
        drive(SIG_ALU, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("t6_mul_issue", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_BR, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t6_busy", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_BR, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            expect_out("t6_memstall_cnt", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        end
        drive(SIG_BR, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t6_cnt_frozen", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clock);
        check_now();
        #1 reset_n = 1'b0;
        #1;
        expect_out("t6_reset_async", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_now();
        @(posedge clock);
        #1 reset_n = 1'b1;
        expect_out("t6_first_after_reset", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_ALU, 5'd1, 5'd2, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("t6_mul_after_reset", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();
        drive(SIG_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("t6_busy_after_reset", 1, 1, 2'b00, 2'b00, 2'b00, 2'b00); cycle_check();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
